// File: rtl/gtech_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, 1-cycle request-to-grant latency; the owner keeps the grant while it holds REQ.
// Define ARB_HOLD_LIMIT_EN to preempt an owner after HOLD_MAX consecutive grant cycles when another requester waits.
module gtech_rr_arbiter #(
   parameter int N        = 4,
   parameter int IW       = 2,
   parameter int HOLD_MAX = 8,
   parameter int CW       = 4
) (
   input  logic          CP,
   input  logic          CD,
   input  logic          EN,
   input  logic [N-1:0]  REQ,
   output logic [N-1:0]  GNT,
   output logic          GNT_VLD,
   output logic [IW-1:0] GNT_ID,
   output logic          BUSY
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] ptr, ptr_nxt;
   logic [IW-1:0] id_nxt;
   logic [N-1:0]  gnt_nxt;
   logic [IW-1:0] after_owner;
   logic [N-1:0]  others;
   logic [IW:0]   first_hit;
   logic [IW:0]   next_hit;
   logic          preempt;

   if (N < 2 || N > 16 || IW != $clog2(N) || HOLD_MAX < 2 || (HOLD_MAX - 1) >= (1 << CW)) begin : g_bad_cfg
      $error("gtech_rr_arbiter: inconsistent parameters");
   end

   // Returns {found, index} of the first set bit at or after start, searching upward mod N.
   function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] start);
      logic [IW:0] res;
      int          idx;
      res = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(start) + i) % N;
         if (r[IW'(idx)]) res = {1'b1, IW'(idx)};
      end
      return res;
   endfunction

   assign after_owner = (int'(GNT_ID) == N - 1) ? '0 : GNT_ID + IW'(1);
   assign others      = REQ & ~GNT;
   assign first_hit   = pick(REQ, ptr);
   assign next_hit    = pick(others, after_owner);

`ifdef ARB_HOLD_LIMIT_EN
   logic [CW-1:0] hold_cnt, hold_cnt_nxt;

   assign preempt = (state == GRANT) && REQ[GNT_ID] && EN && (|others) &&
                    (hold_cnt == CW'(HOLD_MAX - 1));

   // Any grant change restarts the count; otherwise it saturates while the owner is alone.
   always_comb begin
      hold_cnt_nxt = hold_cnt;
      if (gnt_nxt != GNT)
         hold_cnt_nxt = '0;
      else if (state == GRANT && hold_cnt != CW'(HOLD_MAX - 1))
         hold_cnt_nxt = hold_cnt + CW'(1);
   end

   always_ff @(posedge CP or negedge CD) begin
      if (!CD) hold_cnt <= '0;
      else     hold_cnt <= hold_cnt_nxt;
   end
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      gnt_nxt   = GNT;
      id_nxt    = GNT_ID;
      case (state)
         IDLE: begin
            if (EN && first_hit[IW]) begin
               state_nxt = GRANT;
               gnt_nxt   = N'(1) << first_hit[IW-1:0];
               id_nxt    = first_hit[IW-1:0];
            end
         end
         GRANT: begin
            // The releasing owner is masked out of the search, so handover never re-picks it.
            if (!REQ[GNT_ID] || preempt) begin
               ptr_nxt = after_owner;
               if (EN && next_hit[IW]) begin
                  gnt_nxt = N'(1) << next_hit[IW-1:0];
                  id_nxt  = next_hit[IW-1:0];
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = '0;
                  id_nxt    = '0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            id_nxt    = '0;
         end
      endcase
   end

   always_ff @(posedge CP or negedge CD) begin
      if (!CD) begin
         state   <= IDLE;
         ptr     <= '0;
         GNT     <= '0;
         GNT_VLD <= 1'b0;
         GNT_ID  <= '0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         GNT     <= gnt_nxt;
         GNT_VLD <= |gnt_nxt;
         GNT_ID  <= id_nxt;
      end
   end

   assign BUSY = (state == GRANT);

endmodule

// File: tb/tb_gtech_rr_arbiter.sv
// Bench for gtech_rr_arbiter: directed vectors with literal expectations plus a per-cycle reference model.
// Build with ARB_HOLD_LIMIT_EN defined on both files to exercise the hold limit.
module tb_gtech_rr_arbiter;
   localparam int N = 4, IW = 2, HOLD_MAX = 8, CW = 4;

   logic          CP = 1'b0;
   logic          CD = 1'b1;
   logic          EN = 1'b0;
   logic [N-1:0]  REQ = '0;
   logic [N-1:0]  GNT;
   logic          GNT_VLD;
   logic [IW-1:0] GNT_ID;
   logic          BUSY;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   gtech_rr_arbiter #(.N(N), .IW(IW), .HOLD_MAX(HOLD_MAX), .CW(CW)) dut (
      .CP(CP), .CD(CD), .EN(EN), .REQ(REQ),
      .GNT(GNT), .GNT_VLD(GNT_VLD), .GNT_ID(GNT_ID), .BUSY(BUSY)
   );

   always #5 CP = ~CP;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner (-1 = none), rotating start point, cycles the owner has been shown.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_held  = 0;
   int m_k, m_w;

   function automatic int first_from(input logic [N-1:0] r, input int start, input int skip);
      int order[$];
      for (int i = 0; i < N; i++) order.push_back((start + i) % N);
      foreach (order[j])
         if (order[j] != skip && r[order[j]] === 1'b1) return order[j];
      return -1;
   endfunction

   always @(posedge CP or negedge CD) begin
      if (!CD) begin
         m_owner = -1;
         m_ptr   = 0;
         m_held  = 0;
      end else if (m_owner < 0) begin
         if (EN) begin
            m_w = first_from(REQ, m_ptr, -1);
            if (m_w >= 0) begin
               m_owner = m_w;
               m_held  = 1;
            end
         end
      end else begin
         m_k = m_owner;
         m_w = EN ? first_from(REQ, (m_k + 1) % N, m_k) : -1;
         if (REQ[m_k] !== 1'b1) begin
            m_ptr   = (m_k + 1) % N;
            m_owner = m_w;
            m_held  = 1;
         end
`ifdef ARB_HOLD_LIMIT_EN
         else if (m_held >= HOLD_MAX && m_w >= 0) begin
            m_ptr   = (m_k + 1) % N;
            m_owner = m_w;
            m_held  = 1;
         end
`endif
         else m_held++;
      end
   end

   always @(negedge CP) begin
      if (cmp_on) begin
         check("cyc_gnt",  32'(GNT),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
         check("cyc_id",   32'(GNT_ID),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
         check("cyc_vld",  32'(GNT_VLD), 32'(m_owner >= 0));
         check("cyc_busy", 32'(BUSY),    32'(m_owner >= 0));
      end
   end

   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   task automatic expect_gnt(input string name, input logic [N-1:0] g, input int id);
      check({name, "_gnt"}, 32'(GNT), 32'(g));
      check({name, "_id"},  32'(GNT_ID), 32'(id));
      check({name, "_vld"}, 32'(GNT_VLD), 32'(g != '0));
      check({name, "_busy"}, 32'(BUSY), 32'(g != '0));
   endtask

   // Asserts reset between clock edges and verifies outputs clear without an edge.
   task automatic do_reset(input string name);
      #2 CD = 1'b0;
      #1 expect_gnt(name, 4'b0000, 0);
      @(negedge CP);
      CD = 1'b1;
   endtask

   initial begin
      #1 CD = 1'b0;
      #1 expect_gnt("reset", 4'b0000, 0);
      cmp_on = 1'b1;
      @(negedge CP);
      @(negedge CP);
      CD = 1'b1;

      // Single requester: latency 1, release clears next edge.
      REQ = 4'b0001; EN = 1'b1;
      tick(); expect_gnt("single", 4'b0001, 0);
      REQ = 4'b0000;
      tick(); expect_gnt("single_rel", 4'b0000, 0);

      // All requesting, each owner drops after two cycles: 0,1,2,3,0 with no dead cycle.
      do_reset("rst_a");
      REQ = 4'b1111;
      tick(); expect_gnt("rr0",   4'b0001, 0);
      tick(); expect_gnt("rr0h",  4'b0001, 0);
      REQ = 4'b1110; tick(); expect_gnt("rr1",  4'b0010, 1);
      REQ = 4'b1111; tick(); expect_gnt("rr1h", 4'b0010, 1);
      REQ = 4'b1101; tick(); expect_gnt("rr2",  4'b0100, 2);
      REQ = 4'b1111; tick(); expect_gnt("rr2h", 4'b0100, 2);
      REQ = 4'b1011; tick(); expect_gnt("rr3",  4'b1000, 3);
      REQ = 4'b1111; tick(); expect_gnt("rr3h", 4'b1000, 3);
      REQ = 4'b0111; tick(); expect_gnt("rr0b", 4'b0001, 0);
      REQ = 4'b0000; tick(); expect_gnt("rr_idle", 4'b0000, 0);

      // Pointer now 1: grant 2 and release leaves the pointer at 3, then wrap to 0.
      REQ = 4'b0100; tick(); expect_gnt("set_p2", 4'b0100, 2);
      REQ = 4'b0000; tick(); expect_gnt("p3_idle", 4'b0000, 0);
      REQ = 4'b0101; tick(); expect_gnt("wrap0", 4'b0001, 0);
      REQ = 4'b0100; tick(); expect_gnt("wrap2", 4'b0100, 2);
      REQ = 4'b0000; tick(); expect_gnt("wrap_idle", 4'b0000, 0);

      // Enable gating: no new grant while EN=0, but a held grant persists.
      EN = 1'b0; REQ = 4'b0010;
      tick(); expect_gnt("en0_a", 4'b0000, 0);
      tick(); expect_gnt("en0_b", 4'b0000, 0);
      EN = 1'b1;
      tick(); expect_gnt("en1", 4'b0010, 1);
      EN = 1'b0;
      tick(); expect_gnt("en0_hold_a", 4'b0010, 1);
      tick(); expect_gnt("en0_hold_b", 4'b0010, 1);
      REQ = 4'b0100;
      tick(); expect_gnt("en0_release", 4'b0000, 0);
      EN = 1'b1;
      tick(); expect_gnt("en1_again", 4'b0100, 2);

      // Reset mid-grant, then regrant from pointer 0.
      do_reset("rst_mid");
      tick(); expect_gnt("regrant", 4'b0100, 2);
      REQ = 4'b1001;
      tick(); expect_gnt("after_regrant", 4'b1000, 3);
      REQ = 4'b0000;
      tick(); expect_gnt("after_idle", 4'b0000, 0);

      // Two persistent requesters: hold limit alternates every HOLD_MAX cycles, otherwise owner 0 keeps it.
      do_reset("rst_hold");
      REQ = 4'b0011;
      for (int i = 0; i < 18; i++) begin
         tick();
`ifdef ARB_HOLD_LIMIT_EN
         if (i < HOLD_MAX || i >= 2 * HOLD_MAX) expect_gnt("hold_pair", 4'b0001, 0);
         else                                   expect_gnt("hold_pair", 4'b0010, 1);
`else
         expect_gnt("hold_pair", 4'b0001, 0);
`endif
      end

      do_reset("rst_alone");
      REQ = 4'b0001;
      for (int i = 0; i < 12; i++) begin
         tick();
         expect_gnt("hold_alone", 4'b0001, 0);
      end
      REQ = 4'b0000;
      tick(); expect_gnt("final_idle", 4'b0000, 0);

      @(negedge CP);
      cmp_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
